deser_sync: RTL and testbench
=============================

# deser_sync

Serial-to-parallel receiver that recovers WIDTH-bit words from a one-bit-per-clock, LSB-first stream, the same format our serializer emits. The stream carries no frame strobe, so word alignment comes from an in-band SYNC_WORD. The block hunts for that word, confirms lock on consecutive syncs, then delivers data words with a one-cycle valid strobe. It sits at the receive end of a serial link, directly after the bit-sampling flop.

## Interface
- WIDTH, 32: word width in bits. Must be 2 or greater.
- SYNC_WORD, 32'hB5E3_5A1C: alignment word, WIDTH bits wide.
- LOCK_COUNT, 2: number of back-to-back SYNC_WORDs needed to declare lock. Must be 1 or greater.
- MAX_GAP, 64: maximum number of consecutive non-sync words allowed while locked. 0 disables loss detection.
- clk  input  1  clock; one serial bit is sampled on every rising edge.
- reset  input  1  asynchronous, active-high.
- din  input  1  serial data, LSB of each word first.
- realign  input  1  synchronous force back to HUNT. Level-sensitive; highest priority after reset.
- data_out  output  WIDTH  last delivered data word. Held between strobes.
- data_valid  output  1  one-cycle strobe; data_out is new in that cycle.
- locked  output  1  high while in LOCKED.
- lock_lost  output  1  one-cycle pulse when MAX_GAP is exceeded.

## Operation
- Window W (WIDTH bits, registered): updates every cycle as W <= {din, W[WIDTH-1:1]}. After WIDTH shifts, W holds the transmitted word in natural bit order.
- bit_cnt (clog2(WIDTH) bits, wraps WIDTH-1 -> 0): counts the bits of the current word that are already in W.
- word_rdy (registered): set on the edge where bit_cnt wraps to 0. While word_rdy is high, W holds one complete aligned word.
- match = (W == SYNC_WORD), evaluated combinationally.
- States:
  - HUNT: evaluate match every cycle. On match, bit_cnt <= 1 and sync_cnt <= 1. Go to LOCKED if LOCK_COUNT == 1, otherwise to VERIFY. Nothing is emitted.
  - VERIFY: act only when word_rdy is high. If match, increment sync_cnt; when sync_cnt reaches LOCK_COUNT, go to LOCKED and set gap <= 0. If no match, go to HUNT with sync_cnt <= 0.
  - LOCKED: act only when word_rdy is high.
    - If match: the sync word is consumed (not emitted) and gap <= 0.
    - Else if MAX_GAP != 0 and gap == MAX_GAP: the word is discarded, lock_lost pulses, and the state goes to HUNT.
    - Else: data_out <= W, data_valid <= 1, gap <= gap + 1.
- realign high: next state is HUNT; sync_cnt and gap are cleared; any match or word_rdy in that cycle is ignored. data_out is held.
- gap counter width: clog2(MAX_GAP+1). It saturates, so it never wraps.

## Timing
- Reset values: W=0, bit_cnt=0, word_rdy=0, state=HUNT, sync_cnt=0, gap=0, data_out=0, data_valid=0, locked=0, lock_lost=0. Reset asserted mid-word discards the partial word with no strobe.
- Latency: the last bit of a word is sampled at edge e. word_rdy and W are valid in the cycle after e. data_valid is high in the cycle after edge e+1. That is 2 cycles from sampling the last bit to the strobe.
- HUNT match at edge e: bit_cnt=1 after e+1. The next word completes WIDTH-1 edges later, so word boundaries stay contiguous.
- locked rises in the cycle after the edge that performs the final VERIFY match. It falls in the cycle after the edge that leaves LOCKED.
- Strobe spacing while locked is exactly WIDTH cycles, except where a sync word takes the slot.
- A VERIFY failure returns to HUNT. Because W is a sliding window, a match may be found again in the very next cycle.
- Simultaneous events:
  - realign beats word_rdy: no strobe in that cycle.
  - When the last permitted data word (gap reaches MAX_GAP) is followed by a sync, lock is kept.
- A SYNC_WORD pattern that straddles a boundary in LOCKED is ignored. Only aligned words are compared.

## Structure
- Shared package serdes_pkg holds:
  - state encoding localparams HUNT=2'd0, VERIFY=2'd1, LOCKED=2'd2;
  - the default SYNC_WORD constant, shared with the transmit-side framer.
- Sub-module deser_shift_window (W, bit_cnt, word_rdy, and the bit_cnt reload input used on HUNT match).
- The top level holds the FSM, sync_cnt, gap, and the output registers.

## Test plan
Bench parameters: WIDTH=8, SYNC_WORD=8'hB8, LOCK_COUNT=2, MAX_GAP=4.
- Reset for 3 cycles -> all outputs 0; no data_valid in 40 cycles of din=0.
- 3 junk bits, then words B8, B8, 3C, A5 LSB-first -> locked rises after the second B8; data_valid strobes with 3C and then A5, 8 cycles apart. The first strobe comes 2 cycles after the last bit of 3C.
- Words B8, 55, then B8, B8, 11 -> no lock after 55; lock is then gained; exactly one strobe, data_out=11.
- Locked, then words 01, 02, 03, 04, 05 -> 4 strobes (01..04); 05 is not emitted; lock_lost pulses once; locked=0. A repeat of this run with B8 inserted after 04 keeps lock and emits 05.
- Locked, realign pulsed mid-word -> locked=0 next cycle; no strobe for that word; relock needs B8, B8.
- Reset asserted for 1 cycle mid-word while locked, then our serializer (WIDTH=8) looped back sending B8, B8, C3 -> data_out=C3 strobed once.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared definitions for the serial link: receiver FSM state encoding and the
// default alignment word, which the transmit-side framer also inserts.
package serdes_pkg;

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hB5E3_5A1C;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/deser_shift_window.sv
// Sliding WIDTH-bit window over the LSB-first serial stream, plus the bit
// counter that marks word boundaries. The counter can be reloaded so that a
// sync word found by hunting defines where the following words start.
module deser_shift_window
  import serdes_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             reload,
  output logic [WIDTH-1:0] win,
  output logic             word_rdy
);

  localparam int             CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] bit_cnt;

  // Newest bit enters at the MSB so a full window reads in natural bit order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) win <= '0;
    else       win <= {din, win[WIDTH-1:1]};
  end

  // Word boundary tracking; a reload means the bit arriving now is bit 0 of
  // the next word, so it already counts as one bit held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      word_rdy <= 1'b0;
    end else if (reload) begin
      bit_cnt  <= ONE;
      word_rdy <= 1'b0;
    end else begin
      word_rdy <= (bit_cnt == LAST);
      bit_cnt  <= (bit_cnt == LAST) ? '0 : bit_cnt + ONE;
    end
  end

endmodule

// File: rtl/deser_sync.sv
// Serial-to-parallel receiver: hunts for the in-band sync word, confirms lock
// on consecutive aligned syncs, then delivers data words with a one-cycle
// valid strobe. Lock is dropped when too many data words pass without a sync.
module deser_sync
  import serdes_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] SYNC_WORD  = WIDTH'(SYNC_WORD_DEFAULT),
  parameter int               LOCK_COUNT = 2,
  parameter int               MAX_GAP    = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             realign,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             locked,
  output logic             lock_lost
);

  localparam int               SC_W    = cnt_width(LOCK_COUNT + 1);
  localparam int               GAP_W   = cnt_width(MAX_GAP + 1);
  localparam logic [SC_W-1:0]  SC_ONE  = SC_W'(1);
  localparam logic [SC_W-1:0]  SC_LAST = SC_W'(LOCK_COUNT - 1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(MAX_GAP);
  localparam logic [GAP_W-1:0] GAP_SAT = '1;

  logic [WIDTH-1:0] win;
  logic             word_rdy;
  logic             match;
  logic             reload;
  logic             emit;
  logic             lost;
  logic [1:0]       state, state_nxt;
  logic [SC_W-1:0]  sync_cnt, sync_nxt;
  logic [GAP_W-1:0] gap, gap_nxt;

  deser_shift_window #(.WIDTH(WIDTH)) u_window (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .reload   (reload),
    .win      (win),
    .word_rdy (word_rdy)
  );

  assign match = (win == SYNC_WORD);

  // State register together with the sync and gap counters it steers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HUNT;
      sync_cnt <= '0;
      gap      <= '0;
    end else begin
      state    <= state_nxt;
      sync_cnt <= sync_nxt;
      gap      <= gap_nxt;
    end
  end

  // Next-state decisions: HUNT slides bit by bit, VERIFY and LOCKED only look
  // at aligned words. realign overrides everything and freezes data_out.
  always_comb begin
    state_nxt = state;
    sync_nxt  = sync_cnt;
    gap_nxt   = gap;
    emit      = 1'b0;
    lost      = 1'b0;
    reload    = 1'b0;
    if (realign) begin
      state_nxt = HUNT;
      sync_nxt  = '0;
      gap_nxt   = '0;
    end else begin
      case (state)
        HUNT: begin
          if (match) begin
            reload    = 1'b1;
            sync_nxt  = SC_ONE;
            gap_nxt   = '0;
            state_nxt = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (word_rdy) begin
            if (match) begin
              sync_nxt = sync_cnt + SC_ONE;
              if (sync_cnt == SC_LAST) begin
                state_nxt = LOCKED;
                gap_nxt   = '0;
              end
            end else begin
              state_nxt = HUNT;
              sync_nxt  = '0;
            end
          end
        end
        LOCKED: begin
          if (word_rdy) begin
            if (match) begin
              gap_nxt = '0;
            end else if (MAX_GAP != 0 && gap == GAP_LIM) begin
              lost      = 1'b1;
              state_nxt = HUNT;
              sync_nxt  = '0;
            end else begin
              emit = 1'b1;
              if (gap != GAP_SAT) gap_nxt = gap + GAP_ONE;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Output decode: lock indication follows the registered state directly.
  always_comb begin
    locked = (state == LOCKED);
  end

  // Delivered word and one-cycle strobes; data_out holds between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      if (emit) data_out <= win;
      data_valid <= emit;
      lock_lost  <= lost;
    end
  end

endmodule

// File: tb/tb_deser_sync.sv
// Bench for deser_sync (WIDTH=8, SYNC_WORD=B8, LOCK_COUNT=2, MAX_GAP=4):
// a table of hand-derived word outcomes for the directed scenarios, plus a
// random stream compared every cycle against a bit-history reference model.
module tb_deser_sync;

  localparam int         WIDTH = 8;
  localparam logic [7:0] SYNC  = 8'hB8;
  localparam int         LC    = 2;
  localparam int         MG    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       realign = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       locked;
  logic       lock_lost;

  always #5 clk = ~clk;

  deser_sync #(
    .WIDTH      (WIDTH),
    .SYNC_WORD  (SYNC),
    .LOCK_COUNT (LC),
    .MAX_GAP    (MG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .realign    (realign),
    .data_out   (data_out),
    .data_valid (data_valid),
    .locked     (locked),
    .lock_lost  (lock_lost)
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
  endfunction

  // ---------------- reference model ----------------
  // Keeps every bit received since reset; word boundaries are absolute bit
  // indices (boundary + k*WIDTH), so a word is complete when the number of
  // bits received beyond the boundary is a positive multiple of WIDTH.
  bit         hist[$];
  int         mn = 0;
  int         mbound = 0;
  int         mst = 0;      // 0 hunting, 1 verifying, 2 locked
  int         msync = 0;
  int         mgap = 0;
  logic       m_vld = 1'b0;
  logic       m_lost = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         strobe_cnt = 0;
  int         lost_cnt = 0;

  function automatic logic [7:0] mwin();
    logic [7:0] w;
    w = 8'h00;
    for (int i = 0; i < WIDTH; i++) begin
      int idx;
      idx = mn - WIDTH + i;
      if (idx >= 0) w[i] = hist[idx];
    end
    return w;
  endfunction

  function automatic void model_step(input logic b, input logic r, input logic rst);
    logic [7:0] w;
    bit         complete;
    if (rst) begin
      hist.delete();
      mn = 0; mbound = 0; mst = 0; msync = 0; mgap = 0;
      m_vld = 1'b0; m_lost = 1'b0; m_data = 8'h00;
      return;
    end
    w        = mwin();
    complete = (mn > mbound) && (((mn - mbound) % WIDTH) == 0);
    m_vld    = 1'b0;
    m_lost   = 1'b0;
    if (r) begin
      mst = 0; msync = 0; mgap = 0;
    end else if (mst == 0) begin
      if (w == SYNC) begin
        mbound = mn;
        msync  = 1;
        mgap   = 0;
        mst    = (LC == 1) ? 2 : 1;
      end
    end else if (mst == 1) begin
      if (complete) begin
        if (w == SYNC) begin
          msync++;
          if (msync == LC) begin mst = 2; mgap = 0; end
        end else begin
          mst = 0; msync = 0;
        end
      end
    end else begin
      if (complete) begin
        if (w == SYNC) mgap = 0;
        else if (MG != 0 && mgap == MG) begin m_lost = 1'b1; mst = 0; msync = 0; end
        else begin
          m_vld  = 1'b1;
          m_data = w;
          if (mgap < MG) mgap++;
        end
      end
    end
    hist.push_back(b);
    mn++;
  endfunction

  initial forever begin
    @(posedge clk);
    model_step(din, realign, reset);
  end

  // Per-cycle comparison against the model, plus strobe/loss counters.
  initial forever begin
    @(posedge clk);
    #1;
    if (data_valid) strobe_cnt++;
    if (lock_lost) lost_cnt++;
    chk("cyc_valid", data_valid, m_vld);
    chk("cyc_lost", lock_lost, m_lost);
    chk("cyc_locked", locked, (mst == 2));
    chk("cyc_data", data_out, m_data);
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] word;
    int         rl_at;     // bit index carrying a realign pulse, -1 none
    int         rst_at;    // bit index carrying a 1-cycle reset, -1 none
    bit         new_scen;  // reset + 3 junk bits before this word
    bit         ex_vld;
    logic [7:0] ex_data;
    bit         ex_lock;
    bit         ex_lost;
  } vec_t;

  vec_t tbl[$];
  vec_t pend;
  bit   pend_ok = 0;
  int   strb_base = 0;
  int   lost_base = 0;

  function automatic void row(input logic [7:0] w, input bit ns, input bit v, input logic [7:0] d,
                              input bit lk, input bit ls, input int rl, input int rs);
    vec_t e;
    e.word = w; e.new_scen = ns; e.ex_vld = v; e.ex_data = d;
    e.ex_lock = lk; e.ex_lost = ls; e.rl_at = rl; e.rst_at = rs;
    tbl.push_back(e);
  endfunction

  task automatic check_rec(input vec_t v);
    chk($sformatf("rec_%02h_valid", v.word), data_valid, v.ex_vld);
    chk($sformatf("rec_%02h_data", v.word), data_out, v.ex_data);
    chk($sformatf("rec_%02h_locked", v.word), locked, v.ex_lock);
    chk($sformatf("rec_%02h_lost", v.word), lock_lost, v.ex_lost);
  endtask

  // A word's outcome shows two cycles after its last bit, i.e. at the second
  // falling edge of the following word, where the pending record is checked.
  task automatic send_row(input vec_t v);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      if (i == 1 && pend_ok) check_rec(pend);
      if (v.rl_at >= 0 && i == v.rl_at + 1) chk("realign_unlock", locked, 0);
      if (v.rst_at >= 0 && i == v.rst_at + 1) begin
        chk("midreset_unlock", locked, 0);
        chk("midreset_data", data_out, 0);
      end
      realign = (i == v.rl_at);
      reset   = (i == v.rst_at);
      din     = v.word[i];
    end
    pend    = v;
    pend_ok = 1;
  endtask

  task automatic end_scenario(input int exp_strb, input int exp_lost);
    @(negedge clk);
    realign = 1'b0; reset = 1'b0; din = 1'b0;
    @(negedge clk);
    if (pend_ok) check_rec(pend);
    pend_ok = 0;
    @(negedge clk);
    chk("scen_strobes", 32'(strobe_cnt - strb_base), 32'(exp_strb));
    chk("scen_lost", 32'(lost_cnt - lost_base), 32'(exp_lost));
  endtask

  task automatic start_scenario();
    @(negedge clk);
    reset = 1'b1; din = 1'b0; realign = 1'b0;
    repeat (3) @(negedge clk);
    strb_base = strobe_cnt;
    lost_base = lost_cnt;
    reset = 1'b0; din = 1'b1;
    @(negedge clk); din = 1'b0;
    @(negedge clk); din = 1'b1;
  endtask

  initial begin
    int exp_strb;
    int exp_lost;

    // Reset for 3 cycles, then 40 quiet cycles.
    repeat (3) @(negedge clk);
    chk("rst_data", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lost", lock_lost, 0);
    strb_base = strobe_cnt;
    reset = 1'b0; din = 1'b0;
    repeat (40) @(negedge clk);
    chk("quiet_strobes", 32'(strobe_cnt - strb_base), 0);
    chk("quiet_locked", locked, 0);

    //  word  new v  data  lk ls  rl  rst
    row(8'hB8, 1, 0, 8'h00, 0, 0, -1, -1);   // lock then two data words
    row(8'hB8, 0, 0, 8'h00, 1, 0, -1, -1);
    row(8'h3C, 0, 1, 8'h3C, 1, 0, -1, -1);
    row(8'hA5, 0, 1, 8'hA5, 1, 0, -1, -1);
    row(8'hB8, 1, 0, 8'h00, 0, 0, -1, -1);   // failed verify, then relock
    row(8'h55, 0, 0, 8'h00, 0, 0, -1, -1);
    row(8'hB8, 0, 0, 8'h00, 0, 0, -1, -1);
    row(8'hB8, 0, 0, 8'h00, 1, 0, -1, -1);
    row(8'h11, 0, 1, 8'h11, 1, 0, -1, -1);
    row(8'hB8, 1, 0, 8'h00, 0, 0, -1, -1);   // gap exceeded
    row(8'hB8, 0, 0, 8'h00, 1, 0, -1, -1);
    row(8'h01, 0, 1, 8'h01, 1, 0, -1, -1);
    row(8'h02, 0, 1, 8'h02, 1, 0, -1, -1);
    row(8'h03, 0, 1, 8'h03, 1, 0, -1, -1);
    row(8'h04, 0, 1, 8'h04, 1, 0, -1, -1);
    row(8'h05, 0, 0, 8'h04, 0, 1, -1, -1);
    row(8'hB8, 1, 0, 8'h00, 0, 0, -1, -1);   // sync right at the gap limit
    row(8'hB8, 0, 0, 8'h00, 1, 0, -1, -1);
    row(8'h01, 0, 1, 8'h01, 1, 0, -1, -1);
    row(8'h02, 0, 1, 8'h02, 1, 0, -1, -1);
    row(8'h03, 0, 1, 8'h03, 1, 0, -1, -1);
    row(8'h04, 0, 1, 8'h04, 1, 0, -1, -1);
    row(8'hB8, 0, 0, 8'h04, 1, 0, -1, -1);
    row(8'h05, 0, 1, 8'h05, 1, 0, -1, -1);
    row(8'hB8, 1, 0, 8'h00, 0, 0, -1, -1);   // realign mid-word and on word_rdy
    row(8'hB8, 0, 0, 8'h00, 1, 0, -1, -1);
    row(8'h3C, 0, 1, 8'h3C, 1, 0, -1, -1);
    row(8'h5A, 0, 0, 8'h3C, 0, 0,  4, -1);
    row(8'hB8, 0, 0, 8'h3C, 0, 0, -1, -1);
    row(8'hB8, 0, 0, 8'h3C, 1, 0, -1, -1);
    row(8'h77, 0, 1, 8'h77, 1, 0, -1, -1);
    row(8'hE1, 0, 0, 8'h77, 0, 0, -1, -1);
    row(8'h00, 0, 0, 8'h77, 0, 0,  0, -1);
    row(8'hB8, 1, 0, 8'h00, 0, 0, -1, -1);   // reset mid-word while locked
    row(8'hB8, 0, 0, 8'h00, 1, 0, -1, -1);
    row(8'h3C, 0, 1, 8'h3C, 1, 0, -1, -1);
    row(8'h5A, 0, 0, 8'h00, 0, 0, -1,  4);
    row(8'hB8, 0, 0, 8'h00, 0, 0, -1, -1);
    row(8'hB8, 0, 0, 8'h00, 1, 0, -1, -1);
    row(8'hC3, 0, 1, 8'hC3, 1, 0, -1, -1);

    exp_strb = 0;
    exp_lost = 0;
    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].new_scen) begin
        if (k > 0) end_scenario(exp_strb, exp_lost);
        start_scenario();
        exp_strb = 0;
        exp_lost = 0;
      end
      exp_strb += int'(tbl[k].ex_vld);
      exp_lost += int'(tbl[k].ex_lost);
      send_row(tbl[k]);
    end
    end_scenario(exp_strb, exp_lost);

    // Random word stream with occasional misalignment, realign and reset.
    start_scenario();
    for (int w = 0; w < 350; w++) begin
      int         kind;
      int         nbits;
      logic [7:0] word;
      kind  = int'($urandom_range(0, 9));
      nbits = (kind == 9) ? int'($urandom_range(1, 3)) : WIDTH;
      word  = (kind < 4) ? SYNC : 8'($urandom_range(0, 255));
      for (int i = 0; i < nbits; i++) begin
        @(negedge clk);
        realign = ($urandom_range(0, 599) == 0);
        reset   = ($urandom_range(0, 1999) == 0);
        din     = word[i];
      end
    end
    @(negedge clk);
    realign = 1'b0; reset = 1'b0; din = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
